// File: rtl/wb_timeout_guard_pkg.sv
// Shared definitions for the Wishbone downstream timeout guard: FSM state
// encoding, default error read data and counter widths.
package wb_timeout_guard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_RESP = RESP;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  localparam int         TO_CNT_W   = 8;
  localparam logic [7:0] TO_CNT_MAX = 8'hFF;

  // Wait counter only needs to reach TIMEOUT_CYCLES-1.
  function automatic int wait_cnt_width(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Downstream wait counter: counts enabled cycles from a restart and raises tc
// once LIMIT-1 is reached, holding there instead of wrapping.
module wb_timeout_counter #(
  parameter int LIMIT = 255,
  parameter int W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] TC_VAL = W'(LIMIT - 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (restart) begin
      cnt_reg <= '0;
    end else if (en && !tc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tc = (cnt_reg == TC_VAL);

endmodule

// File: rtl/wb_timeout_guard.sv
// Wishbone slave-side guard between the wbs_* ports and wb_interconnect:
// registers each request downstream and answers with ERR_DATA if no ack
// arrives within TIMEOUT_CYCLES. Define WB_TIMEOUT_IRQ_EN to enable irq_o.
module wb_timeout_guard
  import wb_timeout_guard_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        dn_stb_o,
  output logic        dn_cyc_o,
  output logic        dn_we_o,
  output logic [3:0]  dn_sel_o,
  output logic [31:0] dn_adr_o,
  output logic [31:0] dn_dat_o,
  input  logic        dn_ack_i,
  input  logic [31:0] dn_dat_i,
  input  logic        clr_i,
  output logic [7:0]  timeout_cnt_o,
  output logic        timeout_flag_o,
  output logic        irq_o
);

  localparam int WAIT_W = wait_cnt_width(TIMEOUT_CYCLES);

  logic [1:0]          state_reg, state_next;
  logic                dn_req_reg;
  logic                dn_we_reg;
  logic [3:0]          dn_sel_reg;
  logic [31:0]         dn_adr_reg, dn_dat_reg;
  logic [31:0]         rd_dat_reg;
  logic [TO_CNT_W-1:0] to_cnt_reg;
  logic                to_flag_reg;

  logic in_idle, in_busy;
  logic accept, abort, ack_hit, timeout_hit, wait_tc;

  wb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (WAIT_W)
  ) u_wait_cnt (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .restart (!in_busy),
    .en      (in_busy),
    .tc      (wait_tc)
  );

  assign in_idle = (state_reg == ST_IDLE);
  assign in_busy = (state_reg == ST_BUSY);

  // Abort beats ack, and ack beats timeout on the terminal-count cycle.
  assign accept      = in_idle && wbs_stb_i && wbs_cyc_i;
  assign abort       = in_busy && !wbs_cyc_i;
  assign ack_hit     = in_busy && wbs_cyc_i && dn_ack_i;
  assign timeout_hit = in_busy && wbs_cyc_i && !dn_ack_i && wait_tc;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_BUSY;
      ST_BUSY: begin
        if (abort)                       state_next = ST_IDLE;
        else if (ack_hit || timeout_hit) state_next = ST_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg   <= ST_IDLE;
      dn_req_reg  <= 1'b0;
      dn_we_reg   <= 1'b0;
      dn_sel_reg  <= '0;
      dn_adr_reg  <= '0;
      dn_dat_reg  <= '0;
      rd_dat_reg  <= '0;
      to_cnt_reg  <= '0;
      to_flag_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (accept) begin
        dn_req_reg <= 1'b1;
        dn_we_reg  <= wbs_we_i;
        dn_sel_reg <= wbs_sel_i;
        dn_adr_reg <= wbs_adr_i;
        dn_dat_reg <= wbs_dat_i;
      end else if (abort || ack_hit || timeout_hit) begin
        dn_req_reg <= 1'b0;
      end

      if (ack_hit)          rd_dat_reg <= dn_dat_i;
      else if (timeout_hit) rd_dat_reg <= ERR_DATA;

      // A clear coinciding with a timeout still records that timeout.
      if (clr_i) begin
        to_cnt_reg  <= timeout_hit ? TO_CNT_W'(1) : '0;
        to_flag_reg <= timeout_hit;
      end else if (timeout_hit) begin
        if (to_cnt_reg != TO_CNT_MAX) to_cnt_reg <= to_cnt_reg + 1'b1;
        to_flag_reg <= 1'b1;
      end
    end
  end

`ifdef WB_TIMEOUT_IRQ_EN
  logic irq_reg;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) irq_reg <= 1'b0;
    else            irq_reg <= timeout_hit;
  end

  assign irq_o = irq_reg;
`else
  assign irq_o = 1'b0;
`endif

  assign wbs_ack_o      = (state_reg == ST_RESP);
  assign wbs_dat_o      = rd_dat_reg;
  assign dn_stb_o       = dn_req_reg;
  assign dn_cyc_o       = dn_req_reg;
  assign dn_we_o        = dn_we_reg;
  assign dn_sel_o       = dn_sel_reg;
  assign dn_adr_o       = dn_adr_reg;
  assign dn_dat_o       = dn_dat_reg;
  assign timeout_cnt_o  = to_cnt_reg;
  assign timeout_flag_o = to_flag_reg;

endmodule
